pmem_burst_adapter: RTL
=======================

PMEM_BURST_ADAPTER -- requirements
Module: pmem_burst_adapter

Interface
REQ-001 Parameters: none; line = 128 bits = 8 beats of 16 bits, fixed.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 pmem_read  input  1  line read request from arbiter side, level, held until pmem_resp.
REQ-005 pmem_write  input  1  line write request from arbiter side, level, held until pmem_resp.
REQ-006 pmem_address  input  16  line address; bits [3:0] ignored.
REQ-007 pmem_wdata  input  128  write line; beat k = bits [16k+15:16k].
REQ-008 pmem_rdata  output  128  read line, valid when pmem_resp=1 after a read.
REQ-009 pmem_resp  output  1  one-cycle completion pulse.
REQ-010 mem_read  output  1  word read request to 16-bit memory.
REQ-011 mem_write  output  1  word write request to 16-bit memory.
REQ-012 mem_address  output  16  word byte-address {line[15:4], beat[2:0], 1'b0}.
REQ-013 mem_wdata  output  16  write word for current beat.
REQ-014 mem_rdata  input  16  read word, sampled when mem_resp=1 during a read beat.
REQ-015 mem_resp  input  1  word-side completion, one per beat.

Function
REQ-016 States: IDLE, RD_BEAT, WR_BEAT, DONE; 3-bit beat counter.
REQ-017 IDLE: pmem_read=1 -> latch address[15:4], beat=0, go RD_BEAT; else pmem_write=1 -> latch address and pmem_wdata, beat=0, go WR_BEAT; else stay.
REQ-018 pmem_read and pmem_write both 1 in IDLE -> read taken, write ignored (no write to memory).
REQ-019 RD_BEAT: mem_read=1 continuously; on mem_resp store mem_rdata into pmem_rdata beat slot, beat+1; response on beat 7 -> DONE.
REQ-020 WR_BEAT: mem_write=1, mem_wdata = latched line beat slot; on mem_resp beat+1; response on beat 7 -> DONE.
REQ-021 mem_read and mem_write never both 1; both 0 in IDLE and DONE.
REQ-022 DONE: pmem_resp=1 for exactly one cycle, then IDLE unconditionally.
REQ-023 Beats strictly in order 0..7; beat counter wraps 7->0 only on exit to DONE.
REQ-024 Latency with mem_resp tied 1: request sampled in IDLE at edge N -> beats at cycles N+1..N+8 -> pmem_resp at cycle N+9.
REQ-025 mem_resp in IDLE or DONE ignored; no state or data change.
REQ-026 pmem_address/pmem_wdata changes after acceptance ignored; latched copies used.
REQ-027 Request deasserted mid-transaction: transaction still completes, pmem_resp still pulses.
REQ-028 Request still high in IDLE after DONE: accepted as a new transaction (no blocking cycle beyond IDLE).
REQ-029 pmem_rdata holds last completed read line until next read beat overwrites its slot; writes never modify it.
REQ-030 mem_address, mem_wdata stable while request held and mem_resp=0.

Reset
REQ-031 reset=1 at any time -> state IDLE, beat=0, pmem_resp=0, mem_read=0, mem_write=0, pmem_rdata=0, mem_address=0, mem_wdata=0, latched line/address cleared.
REQ-032 Reset mid-transaction: partial line discarded, no pmem_resp issued; first request after release starts at beat 0.

Verification
REQ-033 Read, mem_resp tied 1, pmem_address=0x1234, memory word at A = A -> mem_address 0x1230..0x123E in order, pmem_resp at N+9, pmem_rdata = 0x123E_123C_..._1232_1230.
REQ-034 Write, pmem_address=0x0040, pmem_wdata=0x7777_6666_..._1111_0000, mem_resp delayed 3 cycles per beat -> mem_wdata 0x0000..0x7777 at 0x0040..0x004E, pmem_resp once at N+1+8*4.
REQ-035 pmem_read and pmem_write both 1 -> only mem_read observed, mem_write never 1, pmem_rdata updated.
REQ-036 pmem_read dropped and pmem_address changed after beat 2 -> remaining beats use original line, pmem_resp still pulses once.
REQ-037 reset asserted during beat 4 of a read -> same-cycle outputs zero, no pmem_resp; next read completes all 8 beats from 0.
REQ-038 Stray mem_resp pulses in IDLE; back-to-back read then write with requests held -> no spurious transaction, second accepted on the IDLE cycle after DONE.

Source files
------------

// File: rtl/pmem_burst_adapter.sv
// pmem_burst_adapter: turns 128-bit line reads/writes into eight ordered 16-bit
// word transfers on a narrow memory port, then pulses a one-cycle completion.
module pmem_burst_adapter (
  input  logic         clk,
  input  logic         reset,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [15:0]  mem_address,
  output logic [15:0]  mem_wdata,
  input  logic [15:0]  mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [1:0] {IDLE, RD_BEAT, WR_BEAT, DONE} state_t;

  state_t       r_state;
  logic [2:0]   r_beat;
  logic [11:0]  r_line;
  logic [127:0] r_wline;
  logic [127:0] r_rdata;
  logic         r_pmem_resp;
  logic         r_mem_read;
  logic         r_mem_write;
  logic [15:0]  r_mem_address;
  logic [15:0]  r_mem_wdata;

  logic [2:0]   w_next_beat;
  logic         w_last_beat;
  logic         w_unused_addr_lsbs;

  assign w_next_beat        = r_beat + 3'd1;
  assign w_last_beat        = (r_beat == 3'd7);
  assign w_unused_addr_lsbs = ^pmem_address[3:0];

  // Address and write data for the next beat are precomputed on each response,
  // so the memory side always sees registered, stable values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_beat        <= 3'd0;
      r_line        <= 12'd0;
      r_wline       <= 128'd0;
      r_rdata       <= 128'd0;
      r_pmem_resp   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= 16'd0;
      r_mem_wdata   <= 16'd0;
    end else begin
      r_pmem_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (pmem_read) begin
            r_line        <= pmem_address[15:4];
            r_beat        <= 3'd0;
            r_mem_read    <= 1'b1;
            r_mem_address <= {pmem_address[15:4], 4'h0};
            r_state       <= RD_BEAT;
          end else if (pmem_write) begin
            r_line        <= pmem_address[15:4];
            r_wline       <= pmem_wdata;
            r_beat        <= 3'd0;
            r_mem_write   <= 1'b1;
            r_mem_address <= {pmem_address[15:4], 4'h0};
            r_mem_wdata   <= pmem_wdata[15:0];
            r_state       <= WR_BEAT;
          end
        end
        RD_BEAT: begin
          if (mem_resp) begin
            r_rdata[{r_beat, 4'h0} +: 16] <= mem_rdata;
            r_beat        <= w_next_beat;
            r_mem_address <= {r_line, w_next_beat, 1'b0};
            if (w_last_beat) begin
              r_mem_read  <= 1'b0;
              r_pmem_resp <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        WR_BEAT: begin
          if (mem_resp) begin
            r_beat        <= w_next_beat;
            r_mem_address <= {r_line, w_next_beat, 1'b0};
            r_mem_wdata   <= r_wline[{w_next_beat, 4'h0} +: 16];
            if (w_last_beat) begin
              r_mem_write <= 1'b0;
              r_pmem_resp <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign pmem_rdata  = r_rdata;
  assign pmem_resp   = r_pmem_resp;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;

endmodule
